// File: rtl/input_conditioner.sv
// input_conditioner: per-bit synchroniser, tick-sampled debouncer, edge pulses and sticky change flags
module input_conditioner #(
  parameter int NUM_INPUT_PADS = 70,
  parameter int SYNC_STAGES    = 2,
  parameter int PRESCALE       = 1000,
  parameter int DB_COUNT       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  input  logic                      enable,
  input  logic [NUM_INPUT_PADS-1:0] changed_clr,
  output logic [NUM_INPUT_PADS-1:0] clean_out,
  output logic [NUM_INPUT_PADS-1:0] rise_out,
  output logic [NUM_INPUT_PADS-1:0] fall_out,
  output logic [NUM_INPUT_PADS-1:0] changed_out,
  output logic                      tick_out
);
  localparam int N  = NUM_INPUT_PADS;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(DB_COUNT + 1);
  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic tick_q, tick_d;
  logic [N-1:0] clean_q, clean_d, rise_q, rise_d, fall_q, fall_d, changed_q, changed_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] diff, hit;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], input_in};
    pcnt_d = !enable ? pcnt_q : (pcnt_q == PW'(PRESCALE - 1)) ? '0 : pcnt_q + PW'(1);
    tick_d = enable && (pcnt_d == PW'(PRESCALE - 1));
    diff = sync_q[SYNC_STAGES-1] ^ clean_q;
    hit = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      hit[i] = tick_q && diff[i] && (cnt_q[i] == CW'(DB_COUNT - 1));
      cnt_d[i] = !tick_q ? cnt_q[i] : (!diff[i] || hit[i]) ? '0 : cnt_q[i] + CW'(1);
    end
    clean_d = clean_q ^ hit;
    rise_d = hit & clean_d;
    fall_d = hit & ~clean_d;
    // a set arriving together with a clear wins
    changed_d = (changed_q & ~changed_clr) | rise_d | fall_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      pcnt_q    <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= '0;
    end else begin
      sync_q    <= sync_d;
      pcnt_q    <= pcnt_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end
  assign clean_out   = clean_q;
  assign rise_out    = rise_q;
  assign fall_out    = fall_q;
  assign changed_out = changed_q;
  assign tick_out    = tick_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenario tasks for input_conditioner (PRESCALE=1 and PRESCALE=10 instances)
module tb_input_conditioner;
  localparam int N = 70;
  localparam logic [N-1:0] ONES = {N{1'b1}};
  logic clk = 1'b0;
  logic rst, en, tick;
  logic [N-1:0] in_v, clr, clean, rise, fall, changed;
  logic rst_b, en_b, tick_b;
  logic [N-1:0] in_b, clr_b, clean_b, rise_b, fall_b, changed_b;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  input_conditioner #(.NUM_INPUT_PADS(N), .SYNC_STAGES(2), .PRESCALE(1), .DB_COUNT(4)) dut_a (
    .clk(clk), .rst(rst), .input_in(in_v), .enable(en), .changed_clr(clr),
    .clean_out(clean), .rise_out(rise), .fall_out(fall), .changed_out(changed), .tick_out(tick));
  input_conditioner #(.NUM_INPUT_PADS(N), .SYNC_STAGES(2), .PRESCALE(10), .DB_COUNT(4)) dut_b (
    .clk(clk), .rst(rst_b), .input_in(in_b), .enable(en_b), .changed_clr(clr_b),
    .clean_out(clean_b), .rise_out(rise_b), .fall_out(fall_b), .changed_out(changed_b), .tick_out(tick_b));
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    cyc(3);
    n_cmp++;
    if ({clean, rise, fall, changed, tick} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got clean=%h rise=%h fall=%h changed=%h tick=%b, want all 0", clean, rise, fall, changed, tick);
    end
    rst = 1'b0;
    cyc(5);
    n_cmp++;
    if (clean !== '0) begin n_bad++; $display("FAIL reset_edge5_clean: got %h want 0", clean); end
    cyc(1);
    n_cmp++;
    if (clean !== ONES || rise !== ONES || changed !== ONES || fall !== '0) begin
      n_bad++;
      $display("FAIL reset_edge6: clean=%h rise=%h changed=%h fall=%h, want ones/ones/ones/0", clean, rise, changed, fall);
    end
    cyc(1);
    n_cmp++;
    if (rise !== '0 || clean !== ONES) begin n_bad++; $display("FAIL reset_edge7: rise=%h clean=%h want 0/ones", rise, clean); end
    in_v = '0;
    cyc(6);
    n_cmp++;
    if (fall !== ONES || clean !== '0) begin n_bad++; $display("FAIL reset_fall_all: fall=%h clean=%h want ones/0", fall, clean); end
    cyc(2);
    clr = ONES;
    cyc(1);
    clr = '0;
    n_cmp++;
    if (changed !== '0) begin n_bad++; $display("FAIL reset_clear_all: changed=%h want 0", changed); end
  endtask
  task automatic test_glitch;
    int bad;
    bad = 0;
    in_v[5] = 1'b1;
    cyc(3);
    in_v[5] = 1'b0;
    repeat (12) begin
      if (clean[5] !== 1'b0 || rise[5] !== 1'b0 || changed[5] !== 1'b0) bad++;
      cyc(1);
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL glitch_blocked: %0d cycles with bit5 activity, want 0", bad); end
  endtask
  task automatic test_level;
    in_v[0] = 1'b1;
    cyc(5);
    n_cmp++;
    if (clean[0] !== 1'b0) begin n_bad++; $display("FAIL level_rise_edge5: clean0=%b want 0", clean[0]); end
    cyc(1);
    n_cmp++;
    if (clean[0] !== 1'b1 || rise[0] !== 1'b1 || fall[0] !== 1'b0) begin
      n_bad++; $display("FAIL level_rise_edge6: clean0=%b rise0=%b fall0=%b want 1/1/0", clean[0], rise[0], fall[0]);
    end
    cyc(1);
    n_cmp++;
    if (rise[0] !== 1'b0) begin n_bad++; $display("FAIL level_rise_pulse_width: rise0=%b want 0", rise[0]); end
    in_v[0] = 1'b0;
    cyc(5);
    n_cmp++;
    if (fall[0] !== 1'b0 || clean[0] !== 1'b1) begin n_bad++; $display("FAIL level_fall_edge5: fall0=%b clean0=%b want 0/1", fall[0], clean[0]); end
    cyc(1);
    n_cmp++;
    if (fall[0] !== 1'b1 || clean[0] !== 1'b0 || rise[0] !== 1'b0) begin
      n_bad++; $display("FAIL level_fall_edge6: fall0=%b clean0=%b rise0=%b want 1/0/0", fall[0], clean[0], rise[0]);
    end
    cyc(1);
    n_cmp++;
    if (fall[0] !== 1'b0) begin n_bad++; $display("FAIL level_fall_pulse_width: fall0=%b want 0", fall[0]); end
  endtask
  task automatic test_sticky;
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    n_cmp++;
    if (changed[0] !== 1'b0) begin n_bad++; $display("FAIL sticky_clear1: changed0=%b want 0", changed[0]); end
    in_v[0] = 1'b1;
    cyc(6);
    n_cmp++;
    if (changed[0] !== 1'b1 || rise[0] !== 1'b1) begin n_bad++; $display("FAIL sticky_set_on_rise: changed0=%b rise0=%b want 1/1", changed[0], rise[0]); end
    cyc(2);
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    in_v[0] = 1'b0;
    cyc(5);
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    n_cmp++;
    if (fall[0] !== 1'b1 || changed[0] !== 1'b1) begin n_bad++; $display("FAIL sticky_set_wins: fall0=%b changed0=%b want 1/1", fall[0], changed[0]); end
    cyc(1);
    n_cmp++;
    if (changed[0] !== 1'b1) begin n_bad++; $display("FAIL sticky_holds: changed0=%b want 1", changed[0]); end
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    n_cmp++;
    if (changed[0] !== 1'b0) begin n_bad++; $display("FAIL sticky_clear2: changed0=%b want 0", changed[0]); end
  endtask
  task automatic test_reset_mid;
    in_v[1] = 1'b1;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    n_cmp++;
    if ({clean, rise, fall, changed, tick} !== '0) begin
      n_bad++;
      $display("FAIL midreset_state: clean=%h rise=%h fall=%h changed=%h tick=%b want all 0", clean, rise, fall, changed, tick);
    end
    cyc(5);
    n_cmp++;
    if (clean[1] !== 1'b0) begin n_bad++; $display("FAIL midreset_edge5: clean1=%b want 0", clean[1]); end
    cyc(1);
    n_cmp++;
    if (clean[1] !== 1'b1 || rise[1] !== 1'b1) begin n_bad++; $display("FAIL midreset_edge6: clean1=%b rise1=%b want 1/1", clean[1], rise[1]); end
  endtask
  task automatic test_prescale;
    int k, bad;
    rst_b = 1'b0;
    k = 0;
    while (tick_b !== 1'b1 && k < 20) begin cyc(1); k++; end
    n_cmp++;
    if (tick_b !== 1'b1) begin n_bad++; $display("FAIL prescale_first_tick: no tick within 20 cycles, tick=%b want 1", tick_b); end
    k = 0;
    do begin cyc(1); k++; end while (tick_b !== 1'b1 && k < 20);
    n_cmp++;
    if (k != 10) begin n_bad++; $display("FAIL prescale_period: %0d cycles want 10", k); end
    cyc(3);
    en_b = 1'b0;
    in_b = ONES;
    bad = 0;
    repeat (25) begin
      cyc(1);
      if (tick_b !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL prescale_disabled_tick: %0d ticks want 0", bad); end
    n_cmp++;
    if (clean_b !== '0) begin n_bad++; $display("FAIL prescale_clean_frozen: clean=%h want 0", clean_b); end
    en_b = 1'b1;
    k = 0;
    do begin cyc(1); k++; end while (tick_b !== 1'b1 && k < 20);
    n_cmp++;
    if (k != 7) begin n_bad++; $display("FAIL prescale_resume: %0d cycles to tick want 7", k); end
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; in_v = ONES; clr = '0;
    rst_b = 1'b1; en_b = 1'b1; in_b = '0; clr_b = '0;
    test_reset;
    test_glitch;
    test_level;
    test_sticky;
    test_reset_mid;
    test_prescale;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
